// File: rtl/uart_pkg.sv
// Shared UART types and constants for the Hack UART_TX I/O slot.
// Holds the transmitter state encoding and status-word layout used by the port and its timer.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 217;
  localparam int UART_BUSY_BIT     = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;

  // Status word read back through inM: busy flag on top, last accepted byte at the bottom.
  function automatic logic [15:0] statusWord(input logic busy, input logic [UART_DATA_BITS-1:0] data);
    logic [15:0] word;
    word = '0;
    word[UART_BUSY_BIT] = busy;
    word[UART_DATA_BITS-1:0] = data;
    return word;
  endfunction

endpackage

// File: rtl/uart_tx_port_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count, then reloads.
// tick is combinational from the counter register; clear restarts the period on the next edge, no backpressure.
module baud_tick #(
  parameter int CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: load in IDLE starts a frame, tx/out are registered (1-cycle latency).
// No queueing: a load while busy is dropped, software polls out[15] before writing.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        tx
);

  uartState_t state, stateNext;
  logic [UART_DATA_BITS-1:0] shreg, shregNext;
  logic [UART_DATA_BITS-1:0] lastByte, lastByteNext;
  logic [2:0] bitIdx, bitIdxNext;
  logic       bitDone;
  logic       clearBaud;
  logic       txNext;
  logic [15:0] outNext;

  // Upper write-data bits carry no meaning for this slot.
  logic unusedInHi;
  assign unusedInHi = ^in[15:UART_DATA_BITS];

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uBaudTick (
    .clk  (clk),
    .reset(reset),
    .clear(clearBaud),
    .tick (bitDone)
  );

  always_comb begin
    stateNext    = state;
    shregNext    = shreg;
    lastByteNext = lastByte;
    bitIdxNext   = bitIdx;
    clearBaud    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          stateNext    = START;
          shregNext    = in[UART_DATA_BITS-1:0];
          lastByteNext = in[UART_DATA_BITS-1:0];
          bitIdxNext   = '0;
          clearBaud    = 1'b1;
        end
      end
      START: begin
        if (bitDone) stateNext = DATA;
      end
      DATA: begin
        if (bitDone) begin
          shregNext = shreg >> 1;
          // Index saturates at the last data bit; leaving DATA is what ends the count.
          if (bitIdx == 3'(UART_DATA_BITS - 1)) begin
            stateNext = STOP;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bitDone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered pins line up with the state register.
  always_comb begin
    txNext = 1'b1;
    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = shregNext[0];
      default: txNext = 1'b1;
    endcase
    outNext = statusWord(stateNext != IDLE, lastByteNext);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      lastByte <= '0;
      bitIdx   <= '0;
      tx       <= 1'b1;
      out      <= '0;
    end else begin
      state    <= stateNext;
      shreg    <= shregNext;
      lastByte <= lastByteNext;
      bitIdx   <= bitIdxNext;
      tx       <= txNext;
      out      <= outNext;
    end
  end

endmodule
